pipe_skid_reg: RTL and testbench

Parametrised pipeline stage register with valid/ready handshake, optional two-entry skid buffer, synchronous flush and per-stage bubble gating of control bits. It replaces the fixed-field inter-stage registers (ID/EXE, EXE/MEM, MEM/WB) wherever stalls or back-pressure from memory must be absorbed without a combinational ready path. Control bits (write-back, memory read/write enables) and datapath fields (ALU result, store value, destination) are carried as two packed vectors.

---
 rtl/pipe_skid_reg_if.sv | 37 +++
 rtl/pipe_skid_reg.sv | 162 ++++++++++++++++
 tb/tb_pipe_skid_reg.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_skid_reg_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : pipe_skid_reg_if
// Brief    : Handshake bundle for one pipeline stage register. Carries the
//            upstream valid/ready/ctrl/data, the downstream valid/ready/
//            ctrl/data, the synchronous flush request and the occupancy.
// Revision : 1.0 - initial release
// ============================================================================
interface pipe_skid_reg_if #(
  parameter int CTRL_W = 3,
  parameter int DATA_W = 68
);
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [CTRL_W-1:0] in_ctrl;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [CTRL_W-1:0] out_ctrl;
  logic [DATA_W-1:0] out_data;
  logic [1:0]        count;

  // Environment side: produces upstream entries and downstream ready.
  modport master (
    output flush, in_valid, in_ctrl, in_data, out_ready,
    input  in_ready, out_valid, out_ctrl, out_data, count
  );

  // Stage side: the register itself.
  modport slave (
    input  flush, in_valid, in_ctrl, in_data, out_ready,
    output in_ready, out_valid, out_ctrl, out_data, count
  );
endinterface
`default_nettype wire

// File: rtl/pipe_skid_reg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : pipe_skid_reg
// Brief    : Pipeline stage register with valid/ready handshake. SKID=1 adds
//            a second (skid) entry so in_ready comes straight from a flop;
//            SKID=0 is a single register with combinational in_ready.
//            Control bits are zeroed on reset, flush and bubbles; data bits
//            are left untouched by flush.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_skid_reg #(
  parameter int CTRL_W = 3,
  parameter int DATA_W = 68,
  parameter bit SKID   = 1'b1
) (
  input wire             clk,
  input wire             rst,
  pipe_skid_reg_if.slave bus
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  // Head entry: always the one presented downstream.
  logic              r_main_valid;
  logic [CTRL_W-1:0] r_main_ctrl;
  logic [DATA_W-1:0] r_main_data;

  logic              w_in_ready;
  logic [1:0]        w_count;
  logic              w_accept;
  logic              w_take;

  assign w_accept = bus.in_valid & w_in_ready;
  assign w_take   = r_main_valid & bus.out_ready;

  generate
    if (SKID) begin : g_skid
      state_t            r_state;
      logic              r_skid_valid;
      logic [CTRL_W-1:0] r_skid_ctrl;
      logic [DATA_W-1:0] r_skid_data;
      logic              r_in_ready;
      logic [1:0]        r_count;

      // EMPTY/ONE/FULL controller; in_ready and count are registered so no
      // combinational path exists from out_ready back to in_ready.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_state      <= S_EMPTY;
          r_main_valid <= 1'b0;
          r_main_ctrl  <= '0;
          r_main_data  <= '0;
          r_skid_valid <= 1'b0;
          r_skid_ctrl  <= '0;
          r_skid_data  <= '0;
          r_in_ready   <= 1'b1;
          r_count      <= 2'd0;
        end else if (bus.flush) begin
          // Flush wins over any accept or take in the same cycle.
          r_state      <= S_EMPTY;
          r_main_valid <= 1'b0;
          r_main_ctrl  <= '0;
          r_skid_valid <= 1'b0;
          r_skid_ctrl  <= '0;
          r_in_ready   <= 1'b1;
          r_count      <= 2'd0;
        end else begin
          case (r_state)
            S_EMPTY: begin
              if (w_accept) begin
                r_main_valid <= 1'b1;
                r_main_ctrl  <= bus.in_ctrl;
                r_main_data  <= bus.in_data;
                r_count      <= 2'd1;
                r_state      <= S_ONE;
              end
            end
            S_ONE: begin
              if (w_accept && w_take) begin
                r_main_ctrl <= bus.in_ctrl;
                r_main_data <= bus.in_data;
              end else if (w_accept) begin
                // Downstream stalled: park the new entry behind the head.
                r_skid_valid <= 1'b1;
                r_skid_ctrl  <= bus.in_ctrl;
                r_skid_data  <= bus.in_data;
                r_in_ready   <= 1'b0;
                r_count      <= 2'd2;
                r_state      <= S_FULL;
              end else if (w_take) begin
                r_main_valid <= 1'b0;
                r_main_ctrl  <= '0;
                r_count      <= 2'd0;
                r_state      <= S_EMPTY;
              end
            end
            S_FULL: begin
              if (w_take) begin
                r_main_ctrl  <= r_skid_ctrl;
                r_main_data  <= r_skid_data;
                r_skid_valid <= 1'b0;
                r_skid_ctrl  <= '0;
                r_in_ready   <= 1'b1;
                r_count      <= 2'd1;
                r_state      <= S_ONE;
              end
            end
            default: begin
              r_state      <= S_EMPTY;
              r_main_valid <= 1'b0;
              r_main_ctrl  <= '0;
              r_skid_valid <= 1'b0;
              r_skid_ctrl  <= '0;
              r_in_ready   <= 1'b1;
              r_count      <= 2'd0;
            end
          endcase
        end
      end

      assign w_in_ready = r_in_ready;
      assign w_count    = r_count;
    end else begin : g_noskid
      // Single register: reload on accept, go empty on an unreplaced take.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_main_valid <= 1'b0;
          r_main_ctrl  <= '0;
          r_main_data  <= '0;
        end else if (bus.flush) begin
          r_main_valid <= 1'b0;
          r_main_ctrl  <= '0;
        end else if (w_accept) begin
          r_main_valid <= 1'b1;
          r_main_ctrl  <= bus.in_ctrl;
          r_main_data  <= bus.in_data;
        end else if (w_take) begin
          r_main_valid <= 1'b0;
          r_main_ctrl  <= '0;
        end
      end

      // Ready when empty or when the head leaves this same cycle.
      assign w_in_ready = ~r_main_valid | bus.out_ready;
      assign w_count    = {1'b0, r_main_valid};
    end
  endgenerate

  assign bus.in_ready  = w_in_ready;
  assign bus.count     = w_count;
  assign bus.out_valid = r_main_valid;
  // Bubble gating: control bits can never leak out with an invalid entry.
  assign bus.out_ctrl  = r_main_ctrl & {CTRL_W{r_main_valid}};
  assign bus.out_data  = r_main_data;

endmodule
`default_nettype wire

// File: tb/tb_pipe_skid_reg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_pipe_skid_reg
// Brief    : Directed bench for pipe_skid_reg in both SKID modes with an
//            in-order scoreboard per instance.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_skid_reg;

  localparam int CW = 3;
  localparam int DW = 68;
  typedef logic [CW+DW-1:0] ent_t;

  logic clk;
  logic rst;

  pipe_skid_reg_if #(.CTRL_W(CW), .DATA_W(DW)) ba ();
  pipe_skid_reg_if #(.CTRL_W(CW), .DATA_W(DW)) bb ();

  pipe_skid_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(1'b1)) u_skid (
    .clk (clk),
    .rst (rst),
    .bus (ba.slave)
  );

  pipe_skid_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(1'b0)) u_noskid (
    .clk (clk),
    .rst (rst),
    .bus (bb.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  ent_t qa[$];
  ent_t qb[$];
  int   n_total;
  int   n_pass;

  task automatic chk(input string tag, input logic [70:0] obs, input logic [70:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Sample handshakes at the falling edge, then advance past the next
  // rising edge so the caller can drive/check away from it.
  task automatic step();
    ent_t e;
    @(negedge clk);
    if (!rst) begin
      if (ba.out_valid && ba.out_ready) begin
        if (qa.size() == 0) chk("skid_unexpected_out", {ba.out_ctrl, ba.out_data}, '0);
        else begin
          e = qa.pop_front();
          chk("skid_out", {ba.out_ctrl, ba.out_data}, e);
        end
      end
      if (ba.flush) qa.delete();
      else if (ba.in_valid && ba.in_ready) qa.push_back({ba.in_ctrl, ba.in_data});

      if (bb.out_valid && bb.out_ready) begin
        if (qb.size() == 0) chk("noskid_unexpected_out", {bb.out_ctrl, bb.out_data}, '0);
        else begin
          e = qb.pop_front();
          chk("noskid_out", {bb.out_ctrl, bb.out_data}, e);
        end
      end
      if (bb.flush) qb.delete();
      else if (bb.in_valid && bb.in_ready) qb.push_back({bb.in_ctrl, bb.in_data});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_a(input logic [CW-1:0] c, input logic [DW-1:0] d);
    ba.in_valid = 1'b1;
    ba.in_ctrl  = c;
    ba.in_data  = d;
  endtask

  task automatic send_b(input logic [CW-1:0] c, input logic [DW-1:0] d);
    bb.in_valid = 1'b1;
    bb.in_ctrl  = c;
    bb.in_data  = d;
  endtask

  task automatic drain();
    ba.in_valid  = 1'b0;
    bb.in_valid  = 1'b0;
    ba.out_ready = 1'b1;
    bb.out_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      if (qa.size() == 0 && qb.size() == 0) break;
      step();
    end
    chk("drain_leftover", 71'(qa.size() + qb.size()), 71'd0);
  endtask

  initial begin
    n_total = 0;
    n_pass  = 0;
    rst = 1'b1;
    ba.flush = 1'b0; ba.in_valid = 1'b0; ba.in_ctrl = '0; ba.in_data = '0; ba.out_ready = 1'b0;
    bb.flush = 1'b0; bb.in_valid = 1'b0; bb.in_ctrl = '0; bb.in_data = '0; bb.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset state, both modes
    chk("rst_out_valid", 71'(ba.out_valid), 71'd0);
    chk("rst_out_ctrl",  71'(ba.out_ctrl),  71'd0);
    chk("rst_out_data",  71'(ba.out_data),  71'd0);
    chk("rst_count",     71'(ba.count),     71'd0);
    chk("rst_in_ready",  71'(ba.in_ready),  71'd1);
    chk("rst_b_in_ready", 71'(bb.in_ready), 71'd1);
    chk("rst_b_count",   71'(bb.count),     71'd0);
    rst = 1'b0;

    // Streaming, SKID=1: one-cycle latency, count stays 1
    ba.out_ready = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      send_a(CW'(i), DW'(i));
      step();
      chk("stream_data",  71'(ba.out_data), 71'(i));
      chk("stream_count", 71'(ba.count),    71'd1);
    end
    ba.in_valid = 1'b0;
    step();
    chk("stream_empty_count", 71'(ba.count), 71'd0);

    // Back-pressure, SKID=1: A in main, B in skid, C held upstream
    ba.out_ready = 1'b0;
    send_a(3'd1, 68'hA);
    step();
    chk("bp_count1", 71'(ba.count), 71'd1);
    chk("bp_ready1", 71'(ba.in_ready), 71'd1);
    send_a(3'd2, 68'hB);
    step();
    chk("bp_count2", 71'(ba.count), 71'd2);
    chk("bp_ready0", 71'(ba.in_ready), 71'd0);
    send_a(3'd3, 68'hC);
    step();
    chk("bp_hold_count", 71'(ba.count), 71'd2);
    chk("bp_hold_head", 71'(ba.out_data), 71'hA);
    ba.out_ready = 1'b1;
    step();
    chk("bp_release_head", 71'(ba.out_data), 71'hB);
    chk("bp_release_ready", 71'(ba.in_ready), 71'd1);
    chk("bp_release_count", 71'(ba.count), 71'd1);
    step();
    chk("bp_c_head", 71'(ba.out_data), 71'hC);
    ba.in_valid = 1'b0;
    step();
    chk("bp_done_count", 71'(ba.count), 71'd0);

    // Flush collision at count=2 with accept and take pending
    ba.out_ready = 1'b0;
    send_a(3'd5, 68'hE);
    step();
    send_a(3'd6, 68'hF);
    step();
    chk("fl_pre_count", 71'(ba.count), 71'd2);
    send_a(3'd7, 68'hD);
    ba.flush = 1'b1;
    ba.out_ready = 1'b1;
    step();
    ba.flush = 1'b0;
    ba.in_valid = 1'b0;
    chk("fl_out_valid", 71'(ba.out_valid), 71'd0);
    chk("fl_out_ctrl",  71'(ba.out_ctrl),  71'd0);
    chk("fl_count",     71'(ba.count),     71'd0);
    chk("fl_in_ready",  71'(ba.in_ready),  71'd1);
    repeat (3) step();
    chk("fl_no_d", 71'(ba.out_valid), 71'd0);

    // Bubble gating
    send_a(3'b111, 68'h55);
    step();
    chk("bub_ctrl_on", 71'(ba.out_ctrl), 71'd7);
    ba.in_valid = 1'b0;
    step();
    chk("bub_ctrl_off", 71'(ba.out_ctrl), 71'd0);
    chk("bub_data_kept", 71'(ba.out_data), 71'h55);

    // SKID=0: combinational in_ready and back-to-back replace
    bb.out_ready = 1'b0;
    send_b(3'd1, 68'h100);
    step();
    bb.in_valid = 1'b0;
    #1;
    chk("ns_ready_stall", 71'(bb.in_ready), 71'd0);
    bb.out_ready = 1'b1;
    #1;
    chk("ns_ready_comb", 71'(bb.in_ready), 71'd1);
    send_b(3'd2, 68'h200);
    step();
    chk("ns_replace1", 71'(bb.out_data), 71'h200);
    chk("ns_count1", 71'(bb.count), 71'd1);
    send_b(3'd4, 68'h300);
    step();
    chk("ns_replace2", 71'(bb.out_data), 71'h300);
    chk("ns_count2", 71'(bb.count), 71'd1);
    bb.out_ready = 1'b0;
    send_b(3'd3, 68'h400);
    #1;
    chk("ns_ready_full", 71'(bb.in_ready), 71'd0);
    step();
    chk("ns_hold_head", 71'(bb.out_data), 71'h300);
    drain();
    chk("ns_empty", 71'(bb.count), 71'd0);

    // Asynchronous reset mid-stream with count=2
    ba.out_ready = 1'b0;
    send_a(3'd1, 68'h77);
    step();
    send_a(3'd2, 68'h88);
    step();
    ba.in_valid = 1'b0;
    chk("mr_pre_count", 71'(ba.count), 71'd2);
    #2;
    rst = 1'b1;
    #1;
    chk("mr_out_valid", 71'(ba.out_valid), 71'd0);
    chk("mr_out_ctrl",  71'(ba.out_ctrl),  71'd0);
    chk("mr_out_data",  71'(ba.out_data),  71'd0);
    chk("mr_count",     71'(ba.count),     71'd0);
    chk("mr_in_ready",  71'(ba.in_ready),  71'd1);
    qa.delete();
    qb.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    ba.out_ready = 1'b1;
    send_a(3'd5, 68'h99);
    step();
    chk("mr_recover_data", 71'(ba.out_data), 71'h99);
    chk("mr_recover_count", 71'(ba.count), 71'd1);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
